dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: AW, 32, byte-address width of both requester ports and the memory port.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 m0_req, m0_we  input  1 each  core load/store request; write when we=1.
REQ-005 m0_addr  input  AW; m0_wdata  input  32  core address and store data.
REQ-006 m0_gnt  output  1; m0_rvalid  output  1; m0_rdata  output  32  core grant, read-data valid, read data.
REQ-007 m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same directions, widths and meanings as m0_*, for the loader/debug requester.
REQ-008 mem_we  output  1; mem_addr  output  AW; mem_wdata  output  32  single-port data memory command.
REQ-009 mem_rdata  input  32  memory read data, valid the cycle after a read command (1-cycle synchronous read).
REQ-010 m1_lock  input  1  loader holds bus ownership across consecutive accesses (present only with DMEM_ARB_LOCK_EN).

Function
REQ-011 At most one of m0_gnt/m1_gnt SHALL be 1 in any cycle; gnt is combinational from the current req inputs and registered state.
REQ-012 A request is accepted in a cycle when req=1 and gnt=1; the requester SHALL hold req/we/addr/wdata stable until accepted.
REQ-013 When only one requester asserts req, that requester SHALL be granted in the same cycle.
REQ-014 When both assert req, grant SHALL go to the requester not granted most recently (round-robin register last_gnt; reset value selects m0 as winner of first conflict).
REQ-015 last_gnt SHALL update only on an accepted request.
REQ-016 mem_we/mem_addr/mem_wdata SHALL mirror the granted requester's we/addr/wdata; with no grant, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-017 For an accepted read (we=0), the granted port's rvalid SHALL be 1 exactly one cycle later with rdata=mem_rdata; the other port's rvalid=0.
REQ-018 rdata of a port SHALL be 0 whenever its rvalid=0.
REQ-019 Accepted writes SHALL produce no rvalid.
REQ-020 Back-to-back accepted reads SHALL give rvalid on consecutive cycles, each tagged to its own requester (1-entry owner pipeline register).
REQ-021 Grant is independent of pending rvalid; a new access may be accepted in the cycle a previous read returns.
REQ-022 The arbiter SHALL NOT modify addresses or data; wrap-around and alignment are the memory's concern.

Reset
REQ-023 While rst=1: m0_gnt=m1_gnt=0, mem_we=0, both rvalid=0, both rdata=0, last_gnt=m1 (m0 wins first conflict), lock state cleared.
REQ-024 A read accepted in the cycle rst asserts SHALL NOT produce rvalid after reset.
REQ-025 First grant SHALL be possible in the first cycle with rst=0.

Configuration
REQ-026 Macro DMEM_ARB_LOCK_EN: when defined, m1_lock exists; an accepted m1 access with m1_lock=1 sets lock state, during which m0 SHALL NOT be granted; lock clears on the first cycle m1_lock=0 or m1_req=0.
REQ-027 Without DMEM_ARB_LOCK_EN, the m1_lock port and lock state SHALL be absent and arbitration is pure round-robin per REQ-014.

Verification
REQ-028 Only m0 reads 0x100 (mem_rdata=0xDEADBEEF next cycle) -> m0_gnt=1 same cycle; m0_rvalid=1, m0_rdata=0xDEADBEEF next cycle; m1_rvalid=0.
REQ-029 Both req continuously after reset, 4 cycles -> grants m0,m1,m0,m1; never both gnt.
REQ-030 m1 write 0x200=0x12345678 -> mem_we=1, mem_addr=0x200, mem_wdata=0x12345678 same cycle; no rvalid.
REQ-031 Alternating m0 read 0x10 and m1 read 0x20 on back-to-back cycles -> rvalid m0 then m1 on consecutive cycles with the correct data.
REQ-032 rst asserted in cycle of an accepted m0 read -> no m0_rvalid; all outputs 0 during reset.
REQ-033 (DMEM_ARB_LOCK_EN) m1 with m1_lock=1 for 3 accesses while m0_req=1 -> m1 granted 3 cycles; m0 granted the cycle after m1_lock drops.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory with 1-cycle reads.
// Optional bus lock for requester m1 is compiled in with `define DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int unsigned AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
`ifdef DMEM_ARB_LOCK_EN
    ,
    input  logic          m1_lock
`endif
);

    // last_gnt_q: 0 = m0 granted most recently, 1 = m1 (reset value lets m0 win first conflict)
    logic last_gnt_q, last_gnt_d;
    logic rd_pend_q, rd_pend_d;
    logic rd_owner_q, rd_owner_d;
    logic lock_blk;
    logic acc0, acc1;

`ifdef DMEM_ARB_LOCK_EN
    logic lock_q, lock_d;

    // Lock only holds while m1 keeps both req and lock high.
    always_comb begin
        lock_blk = lock_q & m1_lock & m1_req;
        lock_d   = lock_q;
        if (rst || !m1_lock || !m1_req) begin
            lock_d = 1'b0;
        end else if (acc1) begin
            lock_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        lock_q <= lock_d;
    end
`else
    assign lock_blk = 1'b0;
`endif

    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            if (m0_req && !lock_blk && (!m1_req || last_gnt_q)) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end
        end
    end

    assign acc0 = m0_req & m0_gnt;
    assign acc1 = m1_req & m1_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (m0_gnt) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (m1_gnt) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (acc0) begin
            last_gnt_d = 1'b0;
        end else if (acc1) begin
            last_gnt_d = 1'b1;
        end
        rd_pend_d  = (acc0 & ~m0_we) | (acc1 & ~m1_we);
        rd_owner_d = acc1;
        if (rst) begin
            last_gnt_d = 1'b1;
            rd_pend_d  = 1'b0;
            rd_owner_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        last_gnt_q <= last_gnt_d;
        rd_pend_q  <= rd_pend_d;
        rd_owner_q <= rd_owner_d;
    end

    // Returns are masked during reset so a read issued just before rst never surfaces.
    always_comb begin
        m0_rvalid = ~rst & rd_pend_q & ~rd_owner_q;
        m1_rvalid = ~rst & rd_pend_q & rd_owner_q;
        m0_rdata  = m0_rvalid ? mem_rdata : 32'h0;
        m1_rdata  = m1_rvalid ? mem_rdata : 32'h0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-cycle vector table plus hand-written sequences.
// The lock sequence is compiled only when DMEM_ARB_LOCK_EN is defined.
module tb_dmem_arbiter;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    typedef struct {
        logic        rst;
        logic        r0;
        logic        w0;
        logic [31:0] a0;
        logic [31:0] d0;
        logic        r1;
        logic        w1;
        logic [31:0] a1;
        logic [31:0] d1;
        logic [31:0] mrd;
        logic        g0;
        logic        g1;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic        rv0;
        logic [31:0] rd0;
        logic        rv1;
        logic [31:0] rd1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        m1_lock;

    int total = 0;
    int bad   = 0;

    vec_t vec [19];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_LOCK_EN
        ,
        .m1_lock   (m1_lock)
`endif
    );

    task automatic check(input string name, input logic [132:0] act, input logic [132:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic q0, input logic q1, input logic lk);
        rst     = r;
        m0_req  = q0;
        m1_req  = q1;
        m1_lock = lk;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec[0]  = '{Y, Y, N, 32'h100, 32'h0, Y, N, 32'h20, 32'h0, 32'h0,
                    N, N, N, 32'h0, 32'h0, N, 32'h0, N, 32'h0};
        vec[1]  = '{N, Y, N, 32'h100, 32'h0, N, N, 32'h0, 32'h0, 32'h0,
                    Y, N, N, 32'h100, 32'h0, N, 32'h0, N, 32'h0};
        vec[2]  = '{N, N, N, 32'h0, 32'h0, N, N, 32'h0, 32'h0, 32'hDEADBEEF,
                    N, N, N, 32'h0, 32'h0, Y, 32'hDEADBEEF, N, 32'h0};
        vec[3]  = '{N, N, N, 32'h0, 32'h0, N, N, 32'h0, 32'h0, 32'hDEADBEEF,
                    N, N, N, 32'h0, 32'h0, N, 32'h0, N, 32'h0};
        vec[4]  = '{Y, N, N, 32'h0, 32'h0, N, N, 32'h0, 32'h0, 32'h0,
                    N, N, N, 32'h0, 32'h0, N, 32'h0, N, 32'h0};
        vec[5]  = '{N, Y, N, 32'h10, 32'h0, Y, N, 32'h20, 32'h0, 32'h0,
                    Y, N, N, 32'h10, 32'h0, N, 32'h0, N, 32'h0};
        vec[6]  = '{N, Y, N, 32'h10, 32'h0, Y, N, 32'h20, 32'h0, 32'hA0A00001,
                    N, Y, N, 32'h20, 32'h0, Y, 32'hA0A00001, N, 32'h0};
        vec[7]  = '{N, Y, N, 32'h10, 32'h0, Y, N, 32'h20, 32'h0, 32'hB0B00002,
                    Y, N, N, 32'h10, 32'h0, N, 32'h0, Y, 32'hB0B00002};
        vec[8]  = '{N, Y, N, 32'h10, 32'h0, Y, N, 32'h20, 32'h0, 32'hC0C00003,
                    N, Y, N, 32'h20, 32'h0, Y, 32'hC0C00003, N, 32'h0};
        vec[9]  = '{N, N, N, 32'h0, 32'h0, N, N, 32'h0, 32'h0, 32'hD4,
                    N, N, N, 32'h0, 32'h0, N, 32'h0, Y, 32'hD4};
        vec[10] = '{N, N, N, 32'h0, 32'h0, Y, Y, 32'h200, 32'h12345678, 32'h0,
                    N, Y, Y, 32'h200, 32'h12345678, N, 32'h0, N, 32'h0};
        vec[11] = '{N, N, N, 32'h0, 32'h0, N, N, 32'h0, 32'h0, 32'h55,
                    N, N, N, 32'h0, 32'h0, N, 32'h0, N, 32'h0};
        vec[12] = '{N, Y, Y, 32'h300, 32'hCAFE, Y, N, 32'h40, 32'h77, 32'h0,
                    Y, N, Y, 32'h300, 32'hCAFE, N, 32'h0, N, 32'h0};
        vec[13] = '{N, N, N, 32'h0, 32'h0, Y, N, 32'h40, 32'h77, 32'h0,
                    N, Y, N, 32'h40, 32'h77, N, 32'h0, N, 32'h0};
        vec[14] = '{N, Y, N, 32'h44, 32'h0, N, N, 32'h0, 32'h0, 32'h99,
                    Y, N, N, 32'h44, 32'h0, N, 32'h0, Y, 32'h99};
        vec[15] = '{Y, Y, N, 32'h48, 32'h0, N, N, 32'h0, 32'h0, 32'h11,
                    N, N, N, 32'h0, 32'h0, N, 32'h0, N, 32'h0};
        vec[16] = '{N, N, N, 32'h0, 32'h0, N, N, 32'h0, 32'h0, 32'h22,
                    N, N, N, 32'h0, 32'h0, N, 32'h0, N, 32'h0};
        vec[17] = '{N, Y, N, 32'h48, 32'h0, Y, N, 32'h4C, 32'h0, 32'h0,
                    Y, N, N, 32'h48, 32'h0, N, 32'h0, N, 32'h0};
        vec[18] = '{N, N, N, 32'h0, 32'h0, N, N, 32'h0, 32'h0, 32'h33,
                    N, N, N, 32'h0, 32'h0, Y, 32'h33, N, 32'h0};

        rst = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        m1_lock = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;

        // Inputs change 1 unit after the edge; outputs are sampled mid-cycle.
        for (int i = 0; i < 19; i++) begin
            rst       = vec[i].rst;
            m0_req    = vec[i].r0;  m0_we = vec[i].w0;
            m0_addr   = vec[i].a0;  m0_wdata = vec[i].d0;
            m1_req    = vec[i].r1;  m1_we = vec[i].w1;
            m1_addr   = vec[i].a1;  m1_wdata = vec[i].d1;
            mem_rdata = vec[i].mrd;
            #4;
            check($sformatf("row%0d", i),
                  {m0_gnt, m1_gnt, mem_we, mem_addr, mem_wdata,
                   m0_rvalid, m0_rdata, m1_rvalid, m1_rdata},
                  {vec[i].g0, vec[i].g1, vec[i].mwe, vec[i].maddr, vec[i].mwd,
                   vec[i].rv0, vec[i].rd0, vec[i].rv1, vec[i].rd1});
            next_cycle();
        end

        // Random request patterns: exclusive grant, no idle grant, sole requester always wins.
        m0_we = 1'b1;
        m1_we = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            m0_addr = $urandom;
            m1_addr = $urandom;
            #4;
            check($sformatf("excl%0d", i), 133'(m0_gnt & m1_gnt), 133'(0));
            check($sformatf("busy%0d", i), 133'(m0_gnt | m1_gnt), 133'(m0_req | m1_req));
            if (m0_req != m1_req) begin
                check($sformatf("sole%0d", i), 133'({m0_gnt, m1_gnt}),
                      133'({m0_req, m1_req}));
            end
            next_cycle();
        end

`ifdef DMEM_ARB_LOCK_EN
        m0_we = 1'b0;
        m1_we = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        #4;
        check("lock_a", 133'({m0_gnt, m1_gnt}), 133'(2'b01));
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1);
            #4;
            check($sformatf("lock_hold%0d", i), 133'({m0_gnt, m1_gnt}), 133'(2'b01));
            next_cycle();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        #4;
        check("lock_drop", 133'({m0_gnt, m1_gnt}), 133'(2'b10));
        next_cycle();
`endif

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
